// File: rtl/hp2vga_pkg.sv
// rtl/hp2vga_pkg.sv - shared HP capture / VGA TX types and geometry
package hp2vga_pkg;

  localparam int BRAM_AW = 14;
  localparam int BRAM_DW = 8;

  localparam int DEF_H_ACTIVE = 512;
  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_H_OFFSET = 16;
  localparam int DEF_V_OFFSET = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSKIP,
    ST_LWAIT,
    ST_HSKIP,
    ST_CAPTURE,
    ST_DONE
  } cap_state_t;

endpackage

// File: rtl/hp_rx_capture_if.sv
// rtl/hp_rx_capture_if.sv - frame BRAM write port and frame status
interface hp_rx_capture_if;
  import hp2vga_pkg::*;

  logic [BRAM_AW-1:0] BRAM_WADDR;
  logic [BRAM_DW-1:0] BRAM_DIN;
  logic               BRAM_WE;
  logic               FRAME_SYNC;
  logic               FRAME_ERR;

  modport master (output BRAM_WADDR, BRAM_DIN, BRAM_WE, FRAME_SYNC, FRAME_ERR);
  modport slave  (input  BRAM_WADDR, BRAM_DIN, BRAM_WE, FRAME_SYNC, FRAME_ERR);

endinterface

// File: rtl/hp_sync_edge.sv
// rtl/hp_sync_edge.sv - 2-flop synchroniser with a third flop for rising-edge detect
module hp_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [2:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], async_in};
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/hp_rx_capture.sv
// rtl/hp_rx_capture.sv - captures HP monochrome video into packed frame BRAM bytes
module hp_rx_capture
  import hp2vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int H_OFFSET = DEF_H_OFFSET,
  parameter int V_OFFSET = DEF_V_OFFSET
) (
  input  logic CLK,
  input  logic RST,
  input  logic ENABLE,
  input  logic HP_DCLK,
  input  logic HP_HSYNC,
  input  logic HP_VSYNC,
  input  logic HP_VIDEO,
  hp_rx_capture_if.master bram
);

  localparam int LINE_BYTES = H_ACTIVE / 8;
  localparam int SKIP_MAX   = (H_OFFSET > V_OFFSET) ? H_OFFSET : V_OFFSET;
  localparam int PW         = $clog2(H_ACTIVE + 1);
  localparam int LW         = $clog2(V_ACTIVE + 1);
  localparam int SW         = $clog2(SKIP_MAX + 2);

  logic dclk_rise, hsync_rise, vsync_rise, video_lvl;
  logic dclk_lvl_unused, hsync_lvl_unused, vsync_lvl_unused, video_rise_unused;

  hp_sync_edge u_dclk  (.CLK(CLK), .RST(RST), .async_in(HP_DCLK),  .level(dclk_lvl_unused),  .rise(dclk_rise));
  hp_sync_edge u_hsync (.CLK(CLK), .RST(RST), .async_in(HP_HSYNC), .level(hsync_lvl_unused), .rise(hsync_rise));
  hp_sync_edge u_vsync (.CLK(CLK), .RST(RST), .async_in(HP_VSYNC), .level(vsync_lvl_unused), .rise(vsync_rise));
  hp_sync_edge u_video (.CLK(CLK), .RST(RST), .async_in(HP_VIDEO), .level(video_lvl),        .rise(video_rise_unused));

  cap_state_t         state_q, state_d;
  logic [LW-1:0]      line_q, line_d, line_next;
  logic [PW-1:0]      pix_q, pix_d, pix_next;
  logic [SW-1:0]      skip_q, skip_d, skip_next;
  logic [7:0]         shift_q, shift_d, shift_next;
  logic [BRAM_AW-1:0] waddr_q, waddr_d, addr_next;
  logic [BRAM_DW-1:0] din_q, din_d;
  logic               we_q, we_d, fsync_q, fsync_d, err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      pix_q   <= '0;
      skip_q  <= '0;
      shift_q <= '0;
      waddr_q <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      fsync_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      pix_q   <= pix_d;
      skip_q  <= skip_d;
      shift_q <= shift_d;
      waddr_q <= waddr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      fsync_q <= fsync_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    pix_d      = pix_q;
    skip_d     = skip_q;
    shift_d    = shift_q;
    waddr_d    = waddr_q;
    din_d      = din_q;
    we_d       = 1'b0;
    fsync_d    = 1'b0;
    err_d      = err_q;
    line_next  = line_q + LW'(1);
    pix_next   = pix_q + PW'(1);
    skip_next  = skip_q + SW'(1);
    shift_next = {shift_q[6:0], video_lvl};
    addr_next  = BRAM_AW'(32'(line_q) * LINE_BYTES + 32'(pix_next >> 3) - 1);

    // A VSYNC edge outranks everything else, including a coincident HSYNC.
    if (vsync_rise && state_q != ST_IDLE) begin
      state_d = ST_VSKIP;
      line_d  = '0;
      skip_d  = '0;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vsync_rise && ENABLE) begin
            state_d = ST_VSKIP;
            line_d  = '0;
            skip_d  = '0;
          end
        end
        ST_VSKIP: begin
          if (hsync_rise) begin
            if (skip_next == SW'(V_OFFSET)) begin
              state_d = ST_HSKIP;
              skip_d  = '0;
            end else begin
              skip_d = skip_next;
            end
          end
        end
        ST_LWAIT: begin
          if (hsync_rise) begin
            state_d = ST_HSKIP;
            skip_d  = '0;
          end
        end
        ST_HSKIP: begin
          if (hsync_rise) begin
            skip_d = '0;
          end else if (dclk_rise) begin
            if (skip_next == SW'(H_OFFSET)) begin
              state_d = ST_CAPTURE;
              pix_d   = '0;
            end else begin
              skip_d = skip_next;
            end
          end
        end
        ST_CAPTURE: begin
          if (hsync_rise) begin
            // Short line: drop the partial byte and move on to the next line.
            err_d   = 1'b1;
            line_d  = line_next;
            skip_d  = '0;
            state_d = (line_next == LW'(V_ACTIVE)) ? ST_DONE : ST_HSKIP;
          end else if (dclk_rise) begin
            shift_d = shift_next;
            pix_d   = pix_next;
            if (pix_next[2:0] == 3'd0) begin
              we_d    = 1'b1;
              din_d   = shift_next;
              waddr_d = addr_next;
            end
            if (pix_next == PW'(H_ACTIVE)) begin
              line_d  = line_next;
              state_d = (line_next == LW'(V_ACTIVE)) ? ST_DONE : ST_LWAIT;
            end
          end
        end
        ST_DONE: begin
          fsync_d = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bram.BRAM_WADDR = waddr_q;
  assign bram.BRAM_DIN   = din_q;
  assign bram.BRAM_WE    = we_q;
  assign bram.FRAME_SYNC = fsync_q;
  assign bram.FRAME_ERR  = err_q;

endmodule

// File: tb/tb_hp_rx_capture.sv
// tb/tb_hp_rx_capture.sv - self-checking bench for hp_rx_capture on a reduced frame geometry
module tb_hp_rx_capture;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int HO = 3;
  localparam int VO = 2;
  localparam int LB = H / 8;

  logic CLK      = 1'b0;
  logic RST      = 1'b1;
  logic ENABLE   = 1'b0;
  logic HP_DCLK  = 1'b0;
  logic HP_HSYNC = 1'b0;
  logic HP_VSYNC = 1'b0;
  logic HP_VIDEO = 1'b0;

  hp_rx_capture_if bram ();

  hp_rx_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .H_OFFSET(HO), .V_OFFSET(VO)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .HP_DCLK(HP_DCLK), .HP_HSYNC(HP_HSYNC),
    .HP_VSYNC(HP_VSYNC), .HP_VIDEO(HP_VIDEO), .bram(bram)
  );

  always #10 CLK = ~CLK;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct {
    string      name;
    bit         en;
    int         short_line;
    int         short_len;
    logic [H-1:0] pat;
    int         exp_nwr;
    int         exp_fs;
    int         exp_err;
    int         exp_first;
    int         exp_last;
  } vec_t;

  wr_t got_q[$];
  wr_t exp_q[$];
  int  cyc = 0;
  int  fs_cnt = 0;
  int  fs_cyc = 0;
  int  checks = 0;
  int  failures = 0;

  logic [H-1:0] lbits [V];
  int           npix  [V];
  vec_t         vecs  [7];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bram.BRAM_WE === 1'b1)
      got_q.push_back('{addr: int'(bram.BRAM_WADDR), data: int'(bram.BRAM_DIN), cyc: cyc});
    if (bram.FRAME_SYNC === 1'b1) begin
      fs_cnt = fs_cnt + 1;
      fs_cyc = cyc;
    end
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pix(logic v);
    HP_VIDEO = v;
    HP_DCLK  = 1'b1;
    tick(2 + $urandom_range(0, 1));
    HP_DCLK  = 1'b0;
    tick(2 + $urandom_range(0, 1));
  endtask

  task automatic hs_pulse();
    HP_HSYNC = 1'b1;
    tick(3);
    HP_HSYNC = 1'b0;
    tick(3);
  endtask

  task automatic vs_pulse(bit with_hs);
    HP_VSYNC = 1'b1;
    if (with_hs) HP_HSYNC = 1'b1;
    tick(3);
    HP_VSYNC = 1'b0;
    HP_HSYNC = 1'b0;
    tick(3);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    HP_DCLK = 1'b0; HP_HSYNC = 1'b0; HP_VSYNC = 1'b0; HP_VIDEO = 1'b0;
    tick(4);
    RST = 1'b0;
    tick(2);
  endtask

  task automatic send_line(int l);
    hs_pulse();
    repeat (HO) pix(rbit());
    for (int i = 0; i < npix[l]; i++) pix(i < H ? lbits[l][H-1-i] : rbit());
  endtask

  // Pre-roll lines carry pixels so a miscounted V offset shows up as wrong data.
  task automatic send_body();
    for (int k = 0; k < VO - 1; k++) begin
      hs_pulse();
      repeat (HO + H + 2) pix(rbit());
    end
    for (int l = 0; l < V; l++) send_line(l);
    if (npix[V-1] < H) hs_pulse();
    hs_pulse();
    repeat (HO + H) pix(rbit());
    tick(10);
  endtask

  task automatic model_frame(output int exp_err);
    int nb;
    exp_q.delete();
    exp_err = 0;
    for (int l = 0; l < V; l++) begin
      if (npix[l] < H) exp_err = 1;
      nb = (npix[l] >= H) ? LB : npix[l] / 8;
      for (int b = 0; b < nb; b++)
        exp_q.push_back('{addr: l * LB + b, data: int'(lbits[l][H-1-8*b -: 8]), cyc: 0});
    end
  endtask

  task automatic compare_frame(string tag, int base, int fb);
    int eerr;
    model_frame(eerr);
    check($sformatf("%s nwr", tag), got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), got_q[base+i].addr, exp_q[i].addr);
      check($sformatf("%s data[%0d]", tag, i), got_q[base+i].data, exp_q[i].data);
    end
    check($sformatf("%s fsync", tag), fs_cnt - fb, 1);
    check($sformatf("%s err", tag), int'(bram.FRAME_ERR), eerr);
    if (npix[V-1] >= H && got_q.size() > base)
      check($sformatf("%s fs_timing", tag), fs_cyc - got_q[got_q.size()-1].cyc, 1);
  endtask

  task automatic run_vec(vec_t v);
    int base, fb;
    do_reset();
    ENABLE = v.en;
    for (int l = 0; l < V; l++) begin
      lbits[l] = v.pat;
      npix[l]  = H + $urandom_range(0, 3);
    end
    if (v.short_line >= 0) npix[v.short_line] = v.short_len;
    base = got_q.size();
    fb   = fs_cnt;
    vs_pulse(1'b0);
    send_body();
    check({v.name, " tbl_nwr"}, got_q.size() - base, v.exp_nwr);
    check({v.name, " tbl_fsync"}, fs_cnt - fb, v.exp_fs);
    check({v.name, " tbl_err"}, int'(bram.FRAME_ERR), v.exp_err);
    if (v.exp_first >= 0 && got_q.size() > base) begin
      check({v.name, " tbl_first"}, got_q[base].data, v.exp_first);
      check({v.name, " tbl_last"}, got_q[got_q.size()-1].data, v.exp_last);
    end
    if (v.en) compare_frame(v.name, base, fb);
  endtask

  initial begin
    int base, fb;
    vecs[0] = '{"nominal",    1'b1, -1,  0, 16'h5555, 8, 1, 0, 'h55, 'h55};
    vecs[1] = '{"lastpix",    1'b1, -1,  0, 16'h0001, 8, 1, 0, 'h00, 'h01};
    vecs[2] = '{"offsets",    1'b1, -1,  0, 16'h8000, 8, 1, 0, 'h80, 'h00};
    vecs[3] = '{"short2",     1'b1,  2, 10, 16'hA5C3, 7, 1, 1, 'hA5, 'hC3};
    vecs[4] = '{"shortlast",  1'b1,  3,  4, 16'hFFFF, 6, 1, 1, 'hFF, 'hFF};
    vecs[5] = '{"emptyline0", 1'b1,  0,  0, 16'h3C0F, 6, 1, 1, 'h3C, 'h0F};
    vecs[6] = '{"disabled",   1'b0, -1,  0, 16'hFFFF, 0, 0, 0, -1,   -1};

    tick(3);
    check("rst waddr", int'(bram.BRAM_WADDR), 0);
    check("rst din",   int'(bram.BRAM_DIN), 0);
    check("rst we",    int'(bram.BRAM_WE), 0);
    check("rst fsync", int'(bram.FRAME_SYNC), 0);
    check("rst err",   int'(bram.FRAME_ERR), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    for (int r = 0; r < 6; r++) begin
      bit coinc;
      do_reset();
      ENABLE = 1'b1;
      for (int l = 0; l < V; l++) begin
        lbits[l] = H'($urandom);
        npix[l]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, H - 1)) : H + int'($urandom_range(0, 3));
      end
      coinc = rbit();
      base = got_q.size();
      fb   = fs_cnt;
      vs_pulse(coinc);
      send_body();
      compare_frame($sformatf("rand%0d", r), base, fb);
    end

    // Mid-frame VSYNC: abort during line 2, then a clean frame from address 0.
    do_reset();
    ENABLE = 1'b1;
    for (int l = 0; l < V; l++) begin lbits[l] = H'($urandom); npix[l] = H; end
    base = got_q.size();
    fb   = fs_cnt;
    vs_pulse(1'b0);
    hs_pulse();
    send_line(0);
    send_line(1);
    hs_pulse();
    repeat (HO) pix(rbit());
    repeat (8) pix(rbit());
    vs_pulse(1'b0);
    tick(5);
    check("abort nwr", got_q.size() - base, 5);
    check("abort fsync", fs_cnt - fb, 0);
    check("abort err", int'(bram.FRAME_ERR), 1);
    send_body();
    check("abort restart_addr", (got_q.size() > base + 5) ? got_q[base+5].addr : -1, 0);
    check("abort total_nwr", got_q.size() - base, 13);
    check("abort total_fsync", fs_cnt - fb, 1);

    // RST lands in the cycle that would have carried the first write of line 0.
    do_reset();
    ENABLE = 1'b1;
    base = got_q.size();
    vs_pulse(1'b0);
    hs_pulse();
    hs_pulse();
    repeat (HO) pix(rbit());
    repeat (7) pix(1'b1);
    HP_VIDEO = 1'b1;
    HP_DCLK  = 1'b1;
    tick(2);
    RST = 1'b1;
    tick(1);
    check("midrst we",    int'(bram.BRAM_WE), 0);
    check("midrst fsync", int'(bram.FRAME_SYNC), 0);
    check("midrst waddr", int'(bram.BRAM_WADDR), 0);
    check("midrst din",   int'(bram.BRAM_DIN), 0);
    HP_DCLK = 1'b0;
    tick(3);
    check("midrst nwr", got_q.size() - base, 0);
    RST = 1'b0;
    tick(2);
    for (int l = 0; l < V; l++) begin lbits[l] = H'($urandom); npix[l] = H + 1; end
    base = got_q.size();
    fb   = fs_cnt;
    vs_pulse(1'b0);
    send_body();
    compare_frame("postrst", base, fb);

    // ENABLE dropped mid-frame finishes the frame, then the next VSYNC is ignored.
    do_reset();
    ENABLE = 1'b1;
    for (int l = 0; l < V; l++) begin lbits[l] = H'($urandom); npix[l] = H; end
    base = got_q.size();
    fb   = fs_cnt;
    vs_pulse(1'b0);
    ENABLE = 1'b0;
    send_body();
    compare_frame("endrop", base, fb);
    base = got_q.size();
    fb   = fs_cnt;
    vs_pulse(1'b0);
    send_body();
    check("endrop idle_nwr", got_q.size() - base, 0);
    check("endrop idle_fsync", fs_cnt - fb, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
